// File: rtl/avalon_st_chan_adapter_buf.sv
// rtl/avalon_st_chan_adapter_buf.sv - Avalon-ST channel adapter with registered 2-entry skid buffer
// Maps in_channel to out_channel (+offset), drops out-of-range packets and beats outside a packet.
module avalon_st_chan_adapter_buf #(
  parameter int DATA_W      = 8,
  parameter int IN_CHAN_W   = 1,
  parameter int OUT_CHAN_W  = 8,
  parameter int CHAN_OFFSET = 0,
  parameter int MAX_CHAN    = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [IN_CHAN_W-1:0]  in_channel,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [OUT_CHAN_W-1:0] out_channel,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic [CNT_W-1:0]      drop_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PKT  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IN_CHAN_W-1:0]  chan_q, chan_d;
  logic [CNT_W-1:0]      drop_q, drop_d;
  logic                  in_ready_q, in_ready_d;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic [OUT_CHAN_W-1:0] out_chan_q, out_chan_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eop_q, out_eop_d;

  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]     skid_data_q, skid_data_d;
  logic [OUT_CHAN_W-1:0] skid_chan_q, skid_chan_d;
  logic                  skid_sop_q, skid_sop_d;
  logic                  skid_eop_q, skid_eop_d;

  logic                  accept;
  logic                  fwd;
  logic                  drop_beat;
  logic                  chan_ok;
  logic                  out_free;
  logic [IN_CHAN_W-1:0]  beat_chan;
  logic [OUT_CHAN_W-1:0] beat_chan_map;

  assign accept    = in_valid && in_ready_q;
  assign chan_ok   = 32'(in_channel) <= $unsigned(MAX_CHAN);
  assign out_free  = !out_valid_q || out_ready;

  // The SOP beat already carries its own channel; later beats use the latched one.
  assign beat_chan     = in_startofpacket ? in_channel : chan_q;
  assign beat_chan_map = OUT_CHAN_W'(beat_chan) + OUT_CHAN_W'(CHAN_OFFSET);

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    fwd     = 1'b0;
    if (accept) begin
      if (in_startofpacket) begin
        // A SOP always restarts packet tracking, whatever state we were in.
        if (chan_ok) begin
          fwd     = 1'b1;
          chan_d  = in_channel;
          state_d = in_endofpacket ? ST_IDLE : ST_PKT;
        end else begin
          state_d = in_endofpacket ? ST_IDLE : ST_DROP;
        end
      end else if (state_q == ST_PKT) begin
        fwd = 1'b1;
        if (in_endofpacket) state_d = ST_IDLE;
      end else if (state_q == ST_DROP && in_endofpacket) begin
        state_d = ST_IDLE;
      end
    end
  end

  assign drop_beat = accept && !fwd;

  always_comb begin
    drop_d = drop_q;
    if (drop_beat && drop_q != {CNT_W{1'b1}}) drop_d = drop_q + CNT_W'(1);
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_chan_d  = skid_chan_q;
    skid_sop_d   = skid_sop_q;
    skid_eop_d   = skid_eop_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_chan_d   = skid_chan_q;
        out_sop_d    = skid_sop_q;
        out_eop_d    = skid_eop_q;
        skid_valid_d = fwd;
        if (fwd) begin
          skid_data_d = in_data;
          skid_chan_d = beat_chan_map;
          skid_sop_d  = in_startofpacket;
          skid_eop_d  = in_endofpacket;
        end
      end else begin
        out_valid_d = fwd;
        if (fwd) begin
          out_data_d = in_data;
          out_chan_d = beat_chan_map;
          out_sop_d  = in_startofpacket;
          out_eop_d  = in_endofpacket;
        end
      end
    end else if (fwd) begin
      // Output is held by the sink; park the beat and close in_ready next cycle.
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_chan_d  = beat_chan_map;
      skid_sop_d   = in_startofpacket;
      skid_eop_d   = in_endofpacket;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      chan_q       <= '0;
      drop_q       <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_chan_q   <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_chan_q  <= '0;
      skid_sop_q   <= 1'b0;
      skid_eop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      drop_q       <= drop_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_chan_q  <= skid_chan_d;
      skid_sop_q   <= skid_sop_d;
      skid_eop_q   <= skid_eop_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_channel       = out_chan_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign drop_count        = drop_q;

endmodule
